cdb_arbiter: RTL

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter
//  Purpose  : Common-data-bus arbiter. Three result producers (ALU, LSB, BRU)
//             each own a one-entry holding buffer. Occupied buffers compete
//             round-robin for a single registered broadcast slot per cycle.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_in                 system clock, rising edge
//    rst_in                 synchronous active-low reset
//    rdy_in                 global ready, low freezes all state
//    flush_in               misprediction clear (effective only with rdy_in)
//    src_valid[2:0]         per-source result valid (0=ALU,1=LSB,2=BRU)
//    src_ready[2:0]         per-source accept (combinational)
//    src_rob_id_k, k=0..2   ROB id of source k's result
//    src_value_k,  k=0..2   32-bit result value of source k
//    cdb_valid              registered broadcast valid
//    cdb_rob_id             registered broadcast ROB id
//    cdb_value              registered broadcast value
//    cdb_src                registered index of the granted source
// ============================================================================
module cdb_arbiter #(
    parameter int ROB_SIZE_BIT = 5
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    flush_in,
    input  logic [2:0]              src_valid,
    output logic [2:0]              src_ready,
    input  logic [ROB_SIZE_BIT-1:0] src_rob_id_0,
    input  logic [ROB_SIZE_BIT-1:0] src_rob_id_1,
    input  logic [ROB_SIZE_BIT-1:0] src_rob_id_2,
    input  logic [31:0]             src_value_0,
    input  logic [31:0]             src_value_1,
    input  logic [31:0]             src_value_2,
    output logic                    cdb_valid,
    output logic [ROB_SIZE_BIT-1:0] cdb_rob_id,
    output logic [31:0]             cdb_value,
    output logic [1:0]              cdb_src
);

    localparam int C_NSRC = 3;

    // Holding buffers, one per source
    logic [C_NSRC-1:0]       r_buf_valid;
    logic [ROB_SIZE_BIT-1:0] r_buf_id  [C_NSRC];
    logic [31:0]             r_buf_val [C_NSRC];

    // Round-robin pointer, always in {0,1,2}
    logic [1:0]              r_rr;

    logic                    r_cdb_valid;
    logic [ROB_SIZE_BIT-1:0] r_cdb_rob_id;
    logic [31:0]             r_cdb_value;
    logic [1:0]              r_cdb_src;

    logic [ROB_SIZE_BIT-1:0] w_in_id  [C_NSRC];
    logic [31:0]             w_in_val [C_NSRC];

    logic                    w_active;
    logic [C_NSRC-1:0]       w_req;
    logic                    w_gnt_any;
    logic [1:0]              w_gnt_idx;
    logic [C_NSRC-1:0]       w_grant;
    logic [1:0]              w_rr_next;
    logic [C_NSRC-1:0]       w_src_ready;

    assign w_in_id[0]  = src_rob_id_0;
    assign w_in_id[1]  = src_rob_id_1;
    assign w_in_id[2]  = src_rob_id_2;
    assign w_in_val[0] = src_value_0;
    assign w_in_val[1] = src_value_1;
    assign w_in_val[2] = src_value_2;

    // (base + off) mod 3 for base, off in {0,1,2}
    function automatic logic [1:0] f_rot(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

    // Arbitration only happens on an edge that actually advances state:
    // out of reset, ready, and not flushing.
    assign w_active = rst_in & rdy_in & ~flush_in;
    assign w_req    = r_buf_valid & {C_NSRC{w_active}};

    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = 2'd0;
        for (int i = 0; i < C_NSRC; i++) begin
            if (!w_gnt_any && w_req[f_rot(r_rr, 2'(i))]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = f_rot(r_rr, 2'(i));
            end
        end
    end

    assign w_grant     = w_gnt_any ? (3'b001 << w_gnt_idx) : 3'b000;
    assign w_rr_next   = (w_gnt_idx == 2'd2) ? 2'd0 : (w_gnt_idx + 2'd1);

    // A buffer can accept when empty, or when it drains on this same edge.
    assign w_src_ready = {C_NSRC{w_active}} & (~r_buf_valid | w_grant);
    assign src_ready   = w_src_ready;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_buf_valid <= '0;
        end else if (rdy_in) begin
            for (int k = 0; k < C_NSRC; k++) begin
                if (flush_in) begin
                    r_buf_valid[k] <= 1'b0;
                end else if (src_valid[k] && w_src_ready[k]) begin
                    r_buf_valid[k] <= 1'b1;
                    r_buf_id[k]    <= w_in_id[k];
                    r_buf_val[k]   <= w_in_val[k];
                end else if (w_grant[k]) begin
                    r_buf_valid[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_rr         <= 2'd0;
            r_cdb_valid  <= 1'b0;
            r_cdb_rob_id <= '0;
            r_cdb_value  <= '0;
            r_cdb_src    <= 2'd0;
        end else if (rdy_in) begin
            if (flush_in) begin
                r_rr        <= 2'd0;
                r_cdb_valid <= 1'b0;
            end else begin
                r_cdb_valid <= w_gnt_any;
                if (w_gnt_any) begin
                    r_cdb_rob_id <= r_buf_id[w_gnt_idx];
                    r_cdb_value  <= r_buf_val[w_gnt_idx];
                    r_cdb_src    <= w_gnt_idx;
                    r_rr         <= w_rr_next;
                end
            end
        end
    end

    assign cdb_valid  = r_cdb_valid;
    assign cdb_rob_id = r_cdb_rob_id;
    assign cdb_value  = r_cdb_value;
    assign cdb_src    = r_cdb_src;

endmodule
`default_nettype wire
